snake_engine: RTL

//  Game-logic stage directly upstream of the snake renderer: turns PS/2 key codes and a
//  per-frame tick into the packed {y,x} grid positions of every snake segment.

---
 rtl/snake_engine_if.sv | 28 ++
 rtl/snake_engine.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/snake_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snake_engine_if                                              |
// | Description : Key/tick inputs and segment-position outputs of snake_engine |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface snake_engine_if #(
    parameter int NSEG = 4
);
    logic                 tick;
    logic                 key_valid;
    logic [7:0]           key_code;
    logic [13*NSEG-1:0]   seg_pos;
    logic [1:0]           state;
    logic                 step;
    logic                 died;

    modport master (
        output tick, key_valid, key_code,
        input  seg_pos, state, step, died
    );

    modport slave (
        input  tick, key_valid, key_code,
        output seg_pos, state, step, died
    );
endinterface
`default_nettype wire

// File: rtl/snake_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snake_engine                                                 |
// | Description : Snake game logic: keys + frame ticks -> segment positions.   |
// |               Define SNAKE_WRAP_EN for toroidal wrap instead of walls.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module snake_engine #(
    parameter int NSEG     = 4,
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int MOVE_DIV = 4,
    parameter int START_X  = 3,
    parameter int START_Y  = 0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    snake_engine_if.slave   bus
);
    localparam int         c_cw       = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(MOVE_DIV - 1);
    localparam logic [6:0] c_x_max    = 7'(GRID_W - 1);
    localparam logic [5:0] c_y_max    = 6'(GRID_H - 1);
    localparam logic [1:0] c_dir_right = 2'd0;
    localparam logic [1:0] c_dir_left  = 2'd1;
    localparam logic [1:0] c_dir_down  = 2'd2;
    localparam logic [1:0] c_dir_up    = 2'd3;
`ifdef SNAKE_WRAP_EN
    localparam logic       c_wrap     = 1'b1;
`else
    localparam logic       c_wrap     = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [6:0]        r_seg_x [NSEG];
    logic [5:0]        r_seg_y [NSEG];
    logic [1:0]        r_dir, r_pend;
    logic [c_cw-1:0]   r_frame_cnt;
    logic              r_step, r_died;

    logic              w_arrow, w_space, w_esc, w_arrow_ok;
    logic [1:0]        w_arrow_dir;
    logic              w_tick_run, w_step_due;
    logic [6:0]        w_nxt_x;
    logic [5:0]        w_nxt_y;
    logic              w_wall, w_self, w_collide;

    always_comb begin
        w_arrow     = 1'b0;
        w_arrow_dir = c_dir_right;
        w_space     = 1'b0;
        w_esc       = 1'b0;
        if (bus.key_valid) begin
            case (bus.key_code)
                8'h74:   begin w_arrow = 1'b1; w_arrow_dir = c_dir_right; end
                8'h6B:   begin w_arrow = 1'b1; w_arrow_dir = c_dir_left;  end
                8'h72:   begin w_arrow = 1'b1; w_arrow_dir = c_dir_down;  end
                8'h75:   begin w_arrow = 1'b1; w_arrow_dir = c_dir_up;    end
                8'h29:   w_space = 1'b1;
                8'h76:   w_esc   = 1'b1;
                default: ;
            endcase
        end
    end

    // Opposite directions differ only in bit 0 of the encoding.
    assign w_arrow_ok = w_arrow && (r_state == S_IDLE || r_state == S_RUN) &&
                        (w_arrow_dir != (r_dir ^ 2'b01));
    assign w_tick_run = (r_state == S_RUN) && bus.tick && !w_space && !w_esc;
    assign w_step_due = w_tick_run && (r_frame_cnt == c_cnt_last);

    always_comb begin
        w_nxt_x = r_seg_x[0];
        w_nxt_y = r_seg_y[0];
        w_wall  = 1'b0;
        case (r_pend)
            c_dir_right: if (r_seg_x[0] == c_x_max) begin w_wall = 1'b1; w_nxt_x = 7'd0; end
                         else w_nxt_x = r_seg_x[0] + 7'd1;
            c_dir_left:  if (r_seg_x[0] == 7'd0) begin w_wall = 1'b1; w_nxt_x = c_x_max; end
                         else w_nxt_x = r_seg_x[0] - 7'd1;
            c_dir_down:  if (r_seg_y[0] == c_y_max) begin w_wall = 1'b1; w_nxt_y = 6'd0; end
                         else w_nxt_y = r_seg_y[0] + 6'd1;
            default:     if (r_seg_y[0] == 6'd0) begin w_wall = 1'b1; w_nxt_y = c_y_max; end
                         else w_nxt_y = r_seg_y[0] - 6'd1;
        endcase
        // The tail cell is vacated by this step, so it is excluded.
        w_self = 1'b0;
        for (int i = 0; i < NSEG - 1; i++) begin
            if (r_seg_x[i] == w_nxt_x && r_seg_y[i] == w_nxt_y) w_self = 1'b1;
        end
        w_collide = w_self | (w_wall & ~c_wrap);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_esc) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_arrow_ok) w_state_nxt = S_RUN;
                S_RUN:   if (w_space) w_state_nxt = S_PAUSE;
                         else if (w_step_due && w_collide) w_state_nxt = S_DEAD;
                S_PAUSE: if (w_space) w_state_nxt = S_RUN;
                default: w_state_nxt = S_DEAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset || w_esc) begin
            for (int i = 0; i < NSEG; i++) begin
                r_seg_x[i] <= 7'(START_X - i);
                r_seg_y[i] <= 6'(START_Y);
            end
            r_dir       <= c_dir_right;
            r_pend      <= c_dir_right;
            r_frame_cnt <= '0;
            r_step      <= 1'b0;
            r_died      <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_died <= 1'b0;
            if (w_arrow_ok) r_pend <= w_arrow_dir;
            if (r_state == S_IDLE && w_arrow_ok)
                r_frame_cnt <= '0;
            else if (w_tick_run)
                r_frame_cnt <= w_step_due ? '0 : r_frame_cnt + 1'b1;
            if (w_step_due) begin
                if (w_collide) begin
                    r_died <= 1'b1;
                end else begin
                    r_dir      <= r_pend;
                    r_seg_x[0] <= w_nxt_x;
                    r_seg_y[0] <= w_nxt_y;
                    for (int i = 1; i < NSEG; i++) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                    r_step <= 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_pack
        assign bus.seg_pos[13*gi +: 13] = {r_seg_y[gi], r_seg_x[gi]};
    end

    assign bus.state = r_state;
    assign bus.step  = r_step;
    assign bus.died  = r_died;
endmodule
`default_nettype wire
